// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: enables, mode, select handshake, scan prescale and decoded outputs.
interface decoder_scan_n_if #(
  parameter int SEL_W   = 3,
  parameter int PRESC_W = 8
);
  localparam int OUT_W = 2**SEL_W;

  logic               g1_i;
  logic               g2a_i;
  logic               g2b_i;
  logic               mode_i;
  logic [SEL_W-1:0]   select_i;
  logic               load_valid_i;
  logic               load_ready_o;
  logic [PRESC_W-1:0] presc_i;
  logic [OUT_W-1:0]   outputs_o;
  logic [SEL_W-1:0]   index_o;
  logic               wrap_o;

  modport master (
    output g1_i, g2a_i, g2b_i, mode_i, select_i, load_valid_i, presc_i,
    input  load_ready_o, outputs_o, index_o, wrap_o
  );

  modport slave (
    input  g1_i, g2a_i, g2b_i, mode_i, select_i, load_valid_i, presc_i,
    output load_ready_o, outputs_o, index_o, wrap_o
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W active-low decoder with 74138 enables, direct load and auto-scan.
// Optional DECODER_SCAN_BLANK_EN: one all-ones blanking cycle on every scan advance.
module decoder_scan_n_lane #(
  parameter int SEL_W = 3,
  parameter int LANE  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             drive_d,
  input  logic [SEL_W-1:0] idx_d,
  output logic             line_o
);
  logic line_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) line_q <= 1'b1;
    else         line_q <= ~(drive_d && (idx_d == SEL_W'(LANE)));
  end

  assign line_o = line_q;
endmodule

module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int PRESC_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  decoder_scan_n_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   index_q, index_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               en, ready, xfer, scan_entry, scan_stay, term, advance;
  logic               blank_q, blank_now, drive_d;
  logic [OUT_W-1:0]   lines;

  assign en = bus.g1_i & ~bus.g2a_i & ~bus.g2b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Disable beats mode; otherwise mode alone picks the destination.
  always_comb begin
    state_d = state_q;
    if (!en)
      state_d = IDLE;
    else
      case (state_q)
        IDLE, DIRECT, SCAN: state_d = bus.mode_i ? SCAN : DIRECT;
        default:            state_d = IDLE;
      endcase
  end

  always_comb begin
    ready = (state_q != SCAN);
  end

  assign xfer       = bus.load_valid_i & ready;
  assign scan_entry = (state_d == SCAN) && (state_q != SCAN);
  assign scan_stay  = (state_d == SCAN) && (state_q == SCAN);
  assign term       = (cnt_q >= bus.presc_i);
  assign advance    = scan_stay && !blank_q && term;

  always_comb begin
    index_d = index_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    if (xfer) index_d = bus.select_i;
    if (scan_entry) begin
      index_d = '0;
    end else if (advance) begin
      index_d = index_q + 1'b1;
      wrap_d  = &index_q;
    end else if (scan_stay && !blank_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DECODER_SCAN_BLANK_EN
  // Blank cycle: index already advanced, lines dark, prescaler paused.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blank_q <= 1'b0;
    else         blank_q <= advance;
  end
  assign blank_now = advance;
`else
  assign blank_q   = 1'b0;
  assign blank_now = 1'b0;
`endif

  assign drive_d = (state_d != IDLE) && !blank_now;

  for (genvar i = 0; i < OUT_W; i++) begin : g_lane
    decoder_scan_n_lane #(.SEL_W(SEL_W), .LANE(i)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .drive_d(drive_d),
      .idx_d  (index_d),
      .line_o (lines[i])
    );
  end

  assign bus.outputs_o    = lines;
  assign bus.index_o      = index_q;
  assign bus.wrap_o       = wrap_q;
  assign bus.load_ready_o = ready;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: vector table for enable/direct load, sequences for scan corners.
module tb_decoder_scan_n;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  decoder_scan_n_if #(.SEL_W(3), .PRESC_W(8)) bus ();

  decoder_scan_n #(.SEL_W(3), .PRESC_W(8)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct {
    logic       g1, g2a, g2b, mode, valid;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic [2:0] exp_idx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic g1, input logic g2a, input logic g2b, input logic mode,
                       input logic valid, input logic [2:0] sel);
    bus.g1_i = g1; bus.g2a_i = g2a; bus.g2b_i = g2b;
    bus.mode_i = mode; bus.load_valid_i = valid; bus.select_i = sel;
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] e;
    int k;
    drive(0, 0, 0, 0, 0, 3'd0);
    bus.presc_i = 8'd0;
    #12;
    chk("rst_out", bus.outputs_o, 8'hFF);
    chk("rst_idx", bus.index_o, 0);
    chk("rst_ready", bus.load_ready_o, 1);
    chk("rst_wrap", bus.wrap_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Disabled combinations with select traffic, then enable, sweep, hold, disable+load, re-enable.
    vecs.push_back('{0, 0, 0, 0, 1, 3'd3, 8'hFF, 3'd3});
    vecs.push_back('{1, 1, 0, 0, 1, 3'd5, 8'hFF, 3'd5});
    vecs.push_back('{1, 0, 1, 0, 1, 3'd2, 8'hFF, 3'd2});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd0, 8'hFE, 3'd0});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd1, 8'hFD, 3'd1});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd2, 8'hFB, 3'd2});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd3, 8'hF7, 3'd3});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd4, 8'hEF, 3'd4});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd5, 8'hDF, 3'd5});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd6, 8'hBF, 3'd6});
    vecs.push_back('{1, 0, 0, 0, 1, 3'd7, 8'h7F, 3'd7});
    vecs.push_back('{1, 0, 0, 0, 0, 3'd0, 8'h7F, 3'd7});
    vecs.push_back('{1, 0, 0, 0, 0, 3'd2, 8'h7F, 3'd7});
    vecs.push_back('{0, 0, 0, 0, 1, 3'd4, 8'hFF, 3'd4});
    vecs.push_back('{1, 0, 0, 0, 0, 3'd1, 8'hEF, 3'd4});

    foreach (vecs[i]) begin
      drive(vecs[i].g1, vecs[i].g2a, vecs[i].g2b, vecs[i].mode, vecs[i].valid, vecs[i].sel);
      tick();
      chk($sformatf("vec%0d_out", i), bus.outputs_o, vecs[i].exp_out);
      chk($sformatf("vec%0d_idx", i), bus.index_o, vecs[i].exp_idx);
    end

`ifdef DECODER_SCAN_BLANK_EN
    // Blanking scan from IDLE with presc 1: FF, FE, FE, FF, FD, FD, ...
    drive(0, 0, 0, 1, 0, 3'd0);
    bus.presc_i = 8'd1;
    tick();
    chk("blank_pre", bus.outputs_o, 8'hFF);
    drive(1, 0, 0, 1, 0, 3'd0);
    for (int n = 0; n < 27; n++) begin
      tick();
      k = ((n + 1) / 3) % 8;
      e = 8'hFF;
      if (n % 3 != 2) e[k] = 1'b0;
      chk($sformatf("blank%0d_out", n), bus.outputs_o, e);
      chk($sformatf("blank%0d_idx", n), bus.index_o, k);
      chk($sformatf("blank%0d_wrap", n), bus.wrap_o, (n == 23) ? 1 : 0);
    end
`else
    // Scan presc 2 from DIRECT: 3 cycles per line, wrap on return to 0.
    bus.presc_i = 8'd2;
    drive(1, 0, 0, 1, 0, 3'd0);
    for (int n = 0; n < 27; n++) begin
      tick();
      k = (n / 3) % 8;
      e = 8'hFF;
      e[k] = 1'b0;
      chk($sformatf("scan%0d_out", n), bus.outputs_o, e);
      chk($sformatf("scan%0d_wrap", n), bus.wrap_o, (n == 24) ? 1 : 0);
      if (n == 0) chk("scan_ready", bus.load_ready_o, 0);
    end

    // Lower presc 5 -> 1 while cnt = 3.
    drive(1, 0, 0, 0, 0, 3'd0);
    tick();
    bus.presc_i = 8'd5;
    drive(1, 0, 0, 1, 0, 3'd0);
    tick();
    tick(); tick(); tick();
    chk("presc_hold_idx", bus.index_o, 0);
    bus.presc_i = 8'd1;
    tick();
    chk("presc_low_idx", bus.index_o, 1);
    chk("presc_low_out", bus.outputs_o, 8'hFD);

    // Reach index 5 with presc 0, then mode/disable interplay.
    drive(1, 0, 0, 0, 0, 3'd0);
    tick();
    bus.presc_i = 8'd0;
    drive(1, 0, 0, 1, 0, 3'd0);
    tick();
    for (int n = 0; n < 5; n++) tick();
    chk("scan5_idx", bus.index_o, 5);
    drive(1, 0, 0, 0, 0, 3'd0);
    tick();
    chk("to_direct_out", bus.outputs_o, 8'hDF);
    chk("to_direct_ready", bus.load_ready_o, 1);
    drive(0, 0, 0, 0, 0, 3'd0);
    tick();
    chk("dis_out", bus.outputs_o, 8'hFF);
    drive(1, 0, 0, 0, 0, 3'd0);
    tick();
    chk("reen_out", bus.outputs_o, 8'hDF);
    chk("reen_idx", bus.index_o, 5);

    // Transfer coinciding with scan entry: entry wins.
    drive(1, 0, 0, 1, 1, 3'd6);
    tick();
    chk("xfer_entry_idx", bus.index_o, 0);
    chk("xfer_entry_out", bus.outputs_o, 8'hFE);
    bus.load_valid_i = 1'b0;

    // Async reset mid-scan at index 6.
    for (int n = 0; n < 6; n++) tick();
    chk("pre_rst_idx", bus.index_o, 6);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_out", bus.outputs_o, 8'hFF);
    chk("arst_idx", bus.index_o, 0);
    chk("arst_ready", bus.load_ready_o, 1);
    chk("arst_wrap", bus.wrap_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
